// File: rtl/bcd2bin.sv
// Sequential BCD to binary converter: reverse double-dabble, one bit per cycle,
// with digit, sign, residual and signed-range error detection at the end.
module bcd2bin #(
  parameter int WIDTH  = 6,
  parameter int DIGITS = 2,
  parameter int SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIGITS*4-1:0]   bcd,
  input  logic [3:0]            bcd_sgn,
  output logic [WIDTH-1:0]      bin,
  output logic                  valid,
  output logic                  busy,
  output logic                  err
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] POS_MAX = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic [WIDTH-1:0] NEG_MAX = WIDTH'(1 << (WIDTH - 1));
  localparam logic [3:0] SGN_MINUS = 4'b1010;
  localparam logic [3:0] SGN_PLUS  = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       sgn_q, sgn_d;
  logic             dig_err_q, dig_err_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  // One reverse double-dabble step: shift right, then pull 3 out of any
  // digit that picked up the 8 weight from the digit above it.
  logic [BW+WIDTH-1:0]     sh;
  logic [DIGITS-1:0][3:0]  sh_nib, fix_nib, in_nib;
  logic [DIGITS-1:0]       dig_bad;

  assign sh     = {bcd_q, acc_q} >> 1;
  assign sh_nib = sh[BW+WIDTH-1:WIDTH];
  assign in_nib = bcd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_nib
    assign fix_nib[g] = sh_nib[g][3] ? (sh_nib[g] - 4'd3) : sh_nib[g];
    assign dig_bad[g] = (in_nib[g] > 4'd9);
  end

  // Final result evaluation, only consumed in FINISH.
  logic             is_minus, is_plus, sgn_bad, res_err, rng_bad, fin_err;
  logic [WIDTH-1:0] fin_bin;

  always_comb begin
    is_minus = (SIGNED != 0) && (sgn_q == SGN_MINUS);
    is_plus  = (sgn_q == SGN_PLUS);
    sgn_bad  = (SIGNED != 0) && !(is_minus || is_plus);
    res_err  = |bcd_q;
    rng_bad  = 1'b0;
    if (SIGNED != 0) begin
      if (is_minus) rng_bad = (acc_q > NEG_MAX);
      else          rng_bad = (acc_q > POS_MAX);
    end
    fin_err = dig_err_q | sgn_bad | res_err | rng_bad;
    if (fin_err)       fin_bin = '0;
    else if (is_minus) fin_bin = ~acc_q + WIDTH'(1);
    else               fin_bin = acc_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    acc_d     = acc_q;
    sgn_d     = sgn_q;
    dig_err_d = dig_err_q;
    bin_d     = bin_q;
    err_d     = err_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          bcd_d     = bcd;
          acc_d     = '0;
          sgn_d     = bcd_sgn;
          dig_err_d = |dig_bad;
          busy_d    = 1'b1;
        end
      end
      SHIFT: begin
        bcd_d = fix_nib;
        acc_d = sh[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        bin_d   = fin_bin;
        err_d   = fin_err;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bcd_q     <= '0;
      acc_q     <= '0;
      sgn_q     <= '0;
      dig_err_q <= 1'b0;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      acc_q     <= acc_d;
      sgn_q     <= sgn_d;
      dig_err_q <= dig_err_d;
      bin_q     <= bin_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bin   = bin_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Bench for bcd2bin (WIDTH=6, DIGITS=2, SIGNED=1): decimal-arithmetic model checked
// every cycle, plus directed conversions with literal results and latencies.
module tb_bcd2bin;
  localparam int WIDTH = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] bcd = 8'h00;
  logic [3:0] bcd_sgn = 4'hF;
  logic [5:0] bin;
  logic       valid, busy, err;

  int n_chk = 0;
  int n_fail = 0;

  bcd2bin #(.WIDTH(WIDTH), .DIGITS(2), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd(bcd), .bcd_sgn(bcd_sgn),
    .bin(bin), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from decimal arithmetic: {err, bin}
  function automatic logic [6:0] model(input logic [7:0] b, input logic [3:0] s);
    int hi, lo, mag;
    bit minus, plus;
    logic [5:0] r;
    hi = int'(b[7:4]);
    lo = int'(b[3:0]);
    if (hi > 9 || lo > 9) return 7'b1_000000;
    minus = (s == 4'b1010);
    plus  = (s == 4'b1111);
    if (!minus && !plus) return 7'b1_000000;
    mag = hi * 10 + lo;
    if (mag > 63) return 7'b1_000000;
    if (plus && mag > 31) return 7'b1_000000;
    if (minus && mag > 32) return 7'b1_000000;
    r = minus ? 6'(-mag) : 6'(mag);
    return {1'b0, r};
  endfunction

  // Cycle-level expectation: busy for WIDTH+1 cycles after accept, then a valid pulse.
  int         m_cnt;
  logic [6:0] m_res;
  logic       m_valid;
  logic [6:0] m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_res   <= '0;
      m_valid <= 1'b0;
      m_out   <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt <= WIDTH + 1;
          m_res <= model(bcd, bcd_sgn);
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_out   <= m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_cnt != 0));
    chk("bin", 32'(bin), 32'(m_out[5:0]));
    chk("err", 32'(err), 32'(m_out[6]));
  end

  task automatic run(input string nm, input logic [7:0] b, input logic [3:0] s,
                     input logic [5:0] eb, input logic ee);
    int n, nb;
    @(negedge clk);
    bcd = b; bcd_sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bcd = ~b; bcd_sgn = ~s;
    n = 1; nb = 0;
    while (!valid && n < 30) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd8);
    chk({nm, "_busy_cycles"}, 32'(nb), 32'd7);
    chk({nm, "_bin"}, 32'(bin), 32'(eb));
    chk({nm, "_err"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int vc;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bin", 32'(bin), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run("p31",   8'h31, 4'b1111, 6'b011111, 1'b0);
    run("m32",   8'h32, 4'b1010, 6'b100000, 1'b0);
    run("m00",   8'h00, 4'b1010, 6'b000000, 1'b0);
    run("m05",   8'h05, 4'b1010, 6'b111011, 1'b0);
    run("p32",   8'h32, 4'b1111, 6'b000000, 1'b1);
    run("p99",   8'h99, 4'b1111, 6'b000000, 1'b1);
    run("m33",   8'h33, 4'b1010, 6'b000000, 1'b1);
    run("p1A",   8'h1A, 4'b1111, 6'b000000, 1'b1);
    run("sgn0",  8'h25, 4'b0000, 6'b000000, 1'b1);
    run("p09",   8'h09, 4'b1111, 6'b001001, 1'b0);

    // Abort mid-conversion; bin must drop from the held 9 to 0 right away.
    @(negedge clk);
    bcd = 8'h17; bcd_sgn = 4'b1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bin", 32'(bin), 32'd0);
    chk("abort_valid", 32'(valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    vc = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid) vc++;
    end
    chk("abort_no_valid", 32'(vc), 32'd0);
    run("post_rst", 8'h17, 4'b1010, 6'b101111, 1'b0);

    // Held start with changing inputs: the per-cycle model checks each result.
    vc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      bcd_sgn = ($urandom_range(0, 1) != 0) ? 4'b1010 : 4'b1111;
      @(negedge clk);
      if (valid) vc++;
    end
    start = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (valid) vc++;
    end
    chk("held_valid_count", 32'(vc), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 Parameter WIDTH, default 6: width of the binary result.
REQ-002 Parameter DIGITS, default 2: number of BCD input digits; BCD width = DIGITS*4.
REQ-003 Parameter SIGNED, default 1: 1 applies the sign nibble and produces a two's-complement result; 0 ignores the sign nibble and produces an unsigned result.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  request a conversion; sampled only in IDLE.
REQ-007 bcd  input  DIGITS*4  packed BCD magnitude, most significant digit in the top nibble.
REQ-008 bcd_sgn  input  4  sign nibble: 4'b1010 = minus, 4'b1111 = plus.
REQ-009 bin  output  WIDTH  converted result, registered.
REQ-010 valid  output  1  one-cycle pulse; bin and err are updated in the same cycle.
REQ-011 busy  output  1  high from the cycle after start is accepted until valid is asserted.
REQ-012 err  output  1  error flag for the result being presented.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and FINISH.
REQ-014 IDLE->SHIFT on start=1; bcd and bcd_sgn are captured on that edge, and the iteration counter is cleared.
REQ-015 Start SHALL be ignored in SHIFT and FINISH; inputs may change freely after capture.
REQ-016 In SHIFT, each cycle SHALL shift the {bcd_reg, acc} register right by 1, then subtract 3 from every bcd_reg nibble >= 8 (reverse double-dabble).
REQ-017 SHIFT SHALL run exactly WIDTH cycles, then go to FINISH.
REQ-018 FINISH lasts one cycle and then returns to IDLE; valid=1 and busy=0 in FINISH.
REQ-019 Latency: with start sampled at edge k, valid SHALL be high during the cycle after edge k+WIDTH+1. A continuously held start gives one conversion every WIDTH+2 cycles.
REQ-020 Invalid digit: if any captured nibble is > 9, then err=1 and bin=0.
REQ-021 Invalid sign: if SIGNED=1 and the captured sign is neither 1010 nor 1111, then err=1 and bin=0.
REQ-022 Residual overflow: if bcd_reg is nonzero after WIDTH shifts, then err=1 and bin=0.
REQ-023 Signed range (SIGNED=1): a plus magnitude > 2^(WIDTH-1)-1, or a minus magnitude > 2^(WIDTH-1), SHALL set err=1 and bin=0.
REQ-024 Minus magnitude 0 SHALL give bin=0 with err=0.
REQ-025 Otherwise bin SHALL be acc when the sign is plus, and -acc (two's complement, WIDTH bits) when the sign is minus.
REQ-026 Error checks SHALL NOT shorten latency; error results still take WIDTH+2 cycles.
REQ-027 bin and err SHALL hold their value until the next FINISH.

Reset
REQ-028 rst=1 SHALL immediately force: state=IDLE, bin=0, valid=0, busy=0, err=0, internal registers 0.
REQ-029 Reset during SHIFT SHALL abort the conversion; no valid pulse follows.
REQ-030 The first start is accepted on the first rising edge with rst=0.

Verification (WIDTH=6, DIGITS=2, SIGNED=1)
REQ-031 bcd=8'h31, sgn=1111, start pulse -> busy for 7 cycles, then valid=1, bin=6'b011111, err=0.
REQ-032 bcd=8'h32, sgn=1010 -> bin=6'b100000 (-32), err=0; bcd=8'h00, sgn=1010 -> bin=0, err=0.
REQ-033 bcd=8'h32, sgn=1111 -> err=1, bin=0; bcd=8'h99, sgn=1111 -> err=1 (residual), bin=0.
REQ-034 bcd=8'h1A -> err=1, bin=0, valid still at 7 cycles after start; sgn=4'b0000 -> err=1.
REQ-035 rst asserted 3 cycles into SHIFT -> busy=0 and bin=0 immediately, no valid pulse; the next start converts normally.
REQ-036 start held high for 20 cycles with the input changing each cycle -> exactly one valid per 8 cycles, each matching the input captured at its accepting edge.
